// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that lets NREQ streaming requesters share one
// downstream FIFO write port. A requester wins the port for a whole
// burst, which ends on its last marker or after MAX_BURST beats. Each
// written word carries the winner's ID above the payload.
//
// Ports
//   clk        : single clock, everything on its rising edge
//   rst        : synchronous reset, active-high
//   req_valid  : [NREQ]         per-requester data valid
//   req_last   : [NREQ]         per-requester end-of-burst marker
//   req_data   : [NREQ*WIDTH]   requester i payload at [i*WIDTH +: WIDTH]
//   req_ready  : [NREQ]         per-requester accept (only owner, only in BURST)
//   fifo_full  : downstream FIFO full flag
//   fifo_wen   : downstream FIFO write enable (one per accepted beat)
//   fifo_wdata : [TAGW+WIDTH]   {owner ID, payload}
//   busy       : high while a burst is granted
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 36,
    parameter int MAX_BURST = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [NREQ-1:0]                   req_last,
    input  logic [NREQ*WIDTH-1:0]             req_data,
    output logic [NREQ-1:0]                   req_ready,
    input  logic                              fifo_full,
    output logic                              fifo_wen,
    output logic [$clog2(NREQ)+WIDTH-1:0]     fifo_wdata,
    output logic                              busy
);

    localparam int TAGW = $clog2(NREQ);
    // The counter must be able to hold MAX_BURST itself after the final beat.
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic [TAGW-1:0]   owner;
    logic [TAGW-1:0]   rr_ptr;
    logic [CNTW-1:0]   count;

    logic [TAGW-1:0]   next_owner;
    logic              any_valid;
    logic [TAGW-1:0]   scan_sel;
    int                scan_sum;
    logic [WIDTH-1:0]  owner_data;
    logic              in_burst;
    logic              beat;
    logic              burst_end;

    // Round-robin pick: walk the offsets from the far end back to zero so
    // that the last hit written is the first valid index at or after rr_ptr.
    // rr_ptr + k stays below 2*NREQ, so one conditional subtract is the modulo.
    always_comb begin
        next_owner = rr_ptr;
        any_valid  = 1'b0;
        scan_sum   = 0;
        scan_sel   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NREQ) begin
                scan_sum = scan_sum - NREQ;
            end
            scan_sel = TAGW'(scan_sum);
            if (req_valid[scan_sel]) begin
                next_owner = scan_sel;
                any_valid  = 1'b1;
            end
        end
    end

    // Payload of the current owner, selected from the flattened input bus.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == TAGW'(i)) begin
                owner_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // rst is synchronous, so the state register still reads BURST during the
    // reset cycle; gating with rst keeps the handshake silent on that cycle.
    assign in_burst  = (state == BURST) && !rst;
    assign beat      = in_burst && !fifo_full && req_valid[owner];
    assign burst_end = beat && (req_last[owner] || (count == CNTW'(MAX_BURST - 1)));

    // Only the owner may be accepted, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (in_burst) begin
            req_ready[owner] = !fifo_full;
        end
    end

    assign fifo_wen   = beat;
    assign fifo_wdata = {owner, owner_data};
    assign busy       = in_burst;

    // Burst control: IDLE latches the round-robin winner, BURST counts beats
    // and hands the pointer to the next index once the burst closes. A stalled
    // or starved owner simply keeps the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner <= next_owner;
                        count <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        count <= count + 1'b1;
                        if (burst_end) begin
                            state  <= IDLE;
                            rr_ptr <= (owner == TAGW'(NREQ - 1)) ? '0 : owner + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NREQ=4, WIDTH=36, MAX_BURST=4).
// Each requester is a small source queue that presents its head beat and
// advances when accepted. Expected FIFO words are pushed to a scoreboard in
// the order the arbiter must write them and are popped on every fifo_wen.
// Per-cycle write/busy patterns are given as strings, one character a cycle.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 36;
    localparam int MAX_BURST = 4;
    localparam int TAGW      = $clog2(NREQ);
    localparam int DEPTH     = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_last;
    logic [NREQ*WIDTH-1:0]     req_data;
    logic [NREQ-1:0]           req_ready;
    logic                      fifo_full;
    logic                      fifo_wen;
    logic [TAGW+WIDTH-1:0]     fifo_wdata;
    logic                      busy;

    int compared   = 0;
    int mismatched = 0;

    logic [TAGW+WIDTH-1:0]     exp_q[$];
    logic [WIDTH-1:0]          src_data [NREQ][DEPTH];
    logic                      src_last [NREQ][DEPTH];
    int                        head [NREQ];
    int                        tail [NREQ];

    logic                      obs_wen;
    logic                      obs_busy;
    logic [NREQ-1:0]           obs_ready;
    int                        base2;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one beat on requester r; optionally record it as the next word
    // the FIFO must receive.
    task automatic addBeat(input int r, input logic last, input bit push_it);
        src_data[r][tail[r]] = {$urandom(), 4'(r)};
        src_last[r][tail[r]] = last;
        if (push_it) begin
            exp_q.push_back({TAGW'(r), src_data[r][tail[r]]});
        end
        tail[r]++;
    endtask

    task automatic pushExp(input int r, input int idx);
        exp_q.push_back({TAGW'(r), src_data[r][idx]});
    endtask

    // One clock cycle: drive inputs at the falling edge, sample outputs 1ns
    // later, score any write, then retire accepted beats at the rising edge.
    task automatic applyStimulus(input logic full, input logic rst_in);
        logic [NREQ-1:0] acc;
        @(negedge clk);
        rst       = rst_in;
        fifo_full = full;
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]                = 1'b1;
                req_last[i]                 = src_last[i][head[i]];
                req_data[i*WIDTH +: WIDTH]  = src_data[i][head[i]];
            end else begin
                req_valid[i]                = 1'b0;
                req_last[i]                 = 1'b0;
                req_data[i*WIDTH +: WIDTH]  = '0;
            end
        end
        #1;
        obs_wen   = fifo_wen;
        obs_busy  = busy;
        obs_ready = req_ready;
        acc       = req_valid & req_ready;
        if (fifo_wen === 1'b1) begin
            checkOutput("write_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                checkOutput("wdata", 64'(fifo_wdata), 64'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                head[i]++;
            end
        end
    endtask

    // Run len(wen_s) cycles, checking write and busy per cycle and that
    // nothing is accepted while full or reset is asserted.
    task automatic runCycles(input string name, input string rst_s, input string full_s,
                             input string wen_s, input string busy_s);
        logic f;
        logic r;
        for (int c = 0; c < wen_s.len(); c++) begin
            f = (full_s.getc(c) == "1");
            r = (rst_s.getc(c) == "1");
            applyStimulus(f, r);
            checkOutput($sformatf("%s_wen%0d", name, c), 64'(obs_wen), 64'(wen_s.getc(c) == "1"));
            checkOutput($sformatf("%s_busy%0d", name, c), 64'(obs_busy), 64'(busy_s.getc(c) == "1"));
            if (f || r) begin
                checkOutput($sformatf("%s_ready%0d", name, c), 64'(obs_ready), 64'(0));
            end
        end
        checkOutput($sformatf("%s_sb_drained", name), 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Single requester, 3-beat burst; reset held for two cycles first
        // with the request already pending.
        $display("[TB] single requester burst");
        addBeat(0, 1'b0, 1'b1);
        addBeat(0, 1'b0, 1'b1);
        addBeat(0, 1'b1, 1'b1);
        runCycles("single", "1100000", "0000000", "0001110", "0001110");

        // Round robin after reset: 0,1,2,3,0 with two beats each.
        $display("[TB] round robin");
        runCycles("rr_rst", "1", "0", "0", "0");
        for (int r = 0; r < NREQ; r++) begin
            addBeat(r, 1'b0, 1'b1);
            addBeat(r, 1'b1, 1'b1);
        end
        addBeat(0, 1'b0, 1'b1);
        addBeat(0, 1'b1, 1'b1);
        runCycles("rr", "0000000000000000", "0000000000000000",
                  "0110110110110110", "0110110110110110");

        // Burst cap: requester 2 streams 10 beats, others join mid-burst.
        $display("[TB] burst cap");
        base2 = tail[2];
        for (int k = 0; k < 10; k++) begin
            addBeat(2, (k == 9), 1'b0);
        end
        runCycles("cap_grant", "0", "0", "0", "0");
        addBeat(3, 1'b1, 1'b0);
        addBeat(0, 1'b1, 1'b0);
        addBeat(1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) pushExp(2, base2 + k);
        pushExp(3, tail[3] - 1);
        pushExp(0, tail[0] - 1);
        pushExp(1, tail[1] - 1);
        for (int k = 4; k < 10; k++) pushExp(2, base2 + k);
        runCycles("cap", "0000000000000000000", "0000000000000000000",
                  "1111010101011110110", "1111010101011110110");

        // Wrap: pointer sits at 3, only requester 1 is valid.
        $display("[TB] pointer wrap");
        addBeat(1, 1'b1, 1'b1);
        runCycles("wrap", "000", "000", "010", "010");

        // Backpressure: full for 5 cycles after beat 1 of a 6-beat stream;
        // the cap must still land on the 4th accepted beat.
        $display("[TB] backpressure");
        for (int k = 0; k < 6; k++) begin
            addBeat(2, (k == 5), 1'b1);
        end
        runCycles("bp", "00000000000000", "00111110000000",
                  "01000001110110", "01111111110110");

        // Reset during beat 2 of requester 3; afterwards requester 1 wins
        // because the scan restarts from 0.
        $display("[TB] reset mid-burst");
        addBeat(3, 1'b0, 1'b0);
        addBeat(3, 1'b0, 1'b0);
        addBeat(3, 1'b1, 1'b0);
        addBeat(1, 1'b1, 1'b0);
        pushExp(3, tail[3] - 3);
        pushExp(1, tail[1] - 1);
        pushExp(3, tail[3] - 2);
        pushExp(3, tail[3] - 1);
        runCycles("rst_mid", "001000000", "000000000", "010010110", "010010110");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
